// File: rtl/fmdll_lock_detect.sv
// FMDLL lock detector: declares lock once the DCDL code settles and drops it on sustained slip.
// Optional acquisition timeout is compiled in with `define FMDLL_LOCK_TIMEOUT_EN.
module fmdll_lock_detect #(
  parameter int unsigned CODE_W      = 10,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned UNLOCK_TOL  = 4,
  parameter int unsigned UNLOCK_CNT  = 3,
  parameter int unsigned TIMEOUT_UPD = 1024
) (
  input  logic              clk_ext,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CODE_W-1:0] Q,
  input  logic              upd,
  input  logic              lost_clr,
  output logic              lock,
  output logic              lock_lost,
  output logic [CODE_W-1:0] lock_code,
  output logic              rail,
  output logic [1:0]        state,
  output logic              timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACQ    = 2'b01,
    S_LOCKED = 2'b10,
    S_SLIP   = 2'b11
  } state_t;

  localparam logic [CODE_W-1:0] RAIL_HI  = '1;
  localparam logic [CODE_W:0]   TOL_W    = (CODE_W+1)'(TOL);
  localparam logic [CODE_W:0]   UTOL_W   = (CODE_W+1)'(UNLOCK_TOL);
  localparam logic [7:0]        LOCK_W   = 8'(LOCK_CNT);
  localparam logic [3:0]        UNLOCK_W = 4'(UNLOCK_CNT);

  state_t            state_q;
  logic              upd_dly_q;
  logic [CODE_W-1:0] ref_code_q;
  logic              ref_valid_q;
  logic [7:0]        stab_cnt_q;
  logic [3:0]        slip_cnt_q;
  logic              lock_q;
  logic              lock_lost_q;
  logic [CODE_W-1:0] lock_code_q;
  logic              rail_q;

  function automatic logic [CODE_W:0] absdiff(input logic [CODE_W-1:0] a,
                                              input logic [CODE_W-1:0] b);
    logic [CODE_W:0] ea;
    logic [CODE_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  logic       ev;
  logic       q_rail;
  logic       acq_stable;
  logic       in_win;
  logic [7:0] stab_inc;
  logic [3:0] slip_inc;
  logic       drop;

  always_comb begin
    ev         = upd & ~upd_dly_q;
    q_rail     = (Q == '0) || (Q == RAIL_HI);
    acq_stable = ref_valid_q && !q_rail && (absdiff(Q, ref_code_q) <= TOL_W);
    in_win     = absdiff(Q, lock_code_q) <= UTOL_W;
    stab_inc   = stab_cnt_q + 8'd1;
    slip_inc   = slip_cnt_q + 4'd1;
    // LOCKED holds slip_cnt at 0, so UNLOCK_CNT==1 drops straight from LOCKED
    drop       = ev && !in_win && (slip_inc == UNLOCK_W);
  end

`ifdef FMDLL_LOCK_TIMEOUT_EN
  localparam int unsigned TO_CW = $clog2(TIMEOUT_UPD) + 1;
  localparam logic [TO_CW-1:0] TO_W = TO_CW'(TIMEOUT_UPD);

  logic [TO_CW-1:0] to_cnt_q;
  logic [TO_CW-1:0] to_inc;
  logic             timeout_q;

  assign to_inc  = to_cnt_q + 1'b1;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0 & (TIMEOUT_UPD != 0);
`endif

  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upd_dly_q   <= 1'b0;
      ref_code_q  <= '0;
      ref_valid_q <= 1'b0;
      stab_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      lock_q      <= 1'b0;
      lock_lost_q <= 1'b0;
      lock_code_q <= '0;
      rail_q      <= 1'b0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      upd_dly_q <= upd;
      // Clears come first so a set later in this block wins on the same edge
      if (lost_clr) lock_lost_q <= 1'b0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
      if (lost_clr) timeout_q <= 1'b0;
      if (state_q != S_ACQ) to_cnt_q <= '0;
`endif
      if (!en) begin
        state_q     <= S_IDLE;
        lock_q      <= 1'b0;
        stab_cnt_q  <= '0;
        slip_cnt_q  <= '0;
        ref_valid_q <= 1'b0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
        to_cnt_q    <= '0;
        timeout_q   <= 1'b0;
`endif
      end else begin
        if (ev && state_q != S_IDLE) rail_q <= q_rail;
        case (state_q)
          S_IDLE: state_q <= S_ACQ;
          S_ACQ: begin
            if (ev) begin
              ref_code_q  <= Q;
              ref_valid_q <= 1'b1;
`ifdef FMDLL_LOCK_TIMEOUT_EN
              if (to_inc == TO_W) begin
                timeout_q <= 1'b1;
                to_cnt_q  <= '0;
              end else begin
                to_cnt_q  <= to_inc;
              end
`endif
              if (acq_stable) begin
                if (stab_inc == LOCK_W) begin
                  state_q     <= S_LOCKED;
                  lock_q      <= 1'b1;
                  lock_code_q <= Q;
                  stab_cnt_q  <= '0;
`ifdef FMDLL_LOCK_TIMEOUT_EN
                  to_cnt_q    <= '0;
`endif
                end else begin
                  stab_cnt_q <= stab_inc;
                end
              end else begin
                stab_cnt_q <= '0;
              end
            end
          end
          S_LOCKED, S_SLIP: begin
            if (ev) begin
              if (drop) begin
                state_q     <= S_ACQ;
                lock_q      <= 1'b0;
                lock_lost_q <= 1'b1;
                ref_valid_q <= 1'b0;
                stab_cnt_q  <= '0;
                slip_cnt_q  <= '0;
              end else if (in_win) begin
                state_q    <= S_LOCKED;
                slip_cnt_q <= '0;
              end else begin
                state_q    <= S_SLIP;
                slip_cnt_q <= slip_inc;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign lock      = lock_q;
  assign lock_lost = lock_lost_q;
  assign lock_code = lock_code_q;
  assign rail      = rail_q;
  assign state     = state_q;

endmodule
